// File: rtl/evt_ser_pkg.sv
// Shared types and helpers for the event one-hot serializer.
// Latency: n/a (types, constants and a constant function only).
// Backpressure: n/a.
package evt_ser_pkg;

    localparam int N_DEFAULT = 8;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Bits needed to hold an index in 0..n-1 (at least 1).
    function automatic int idx_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/onehot_select.sv
// Combinational picker: first set bit of vec, searching upward from start_ptr+1 mod N.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; result is exactly one-hot whenever vec is nonzero, zero otherwise.
//
// Ports:
//   vec       in  N   candidate bits
//   start_ptr in  PW  search begins at start_ptr+1 (start_ptr=N-1 gives lowest-index priority)
//   onehot    out N   selected bit
module onehot_select
    import evt_ser_pkg::*;
#(
    parameter int N  = N_DEFAULT,
    parameter int PW = idx_width(N)
) (
    input  logic [N-1:0]  vec,
    input  logic [PW-1:0] start_ptr,
    output logic [N-1:0]  onehot
);

    logic          found;
    logic [PW:0]   pos;

    always_comb begin
        onehot = '0;
        found  = 1'b0;
        pos    = '0;
        for (int i = 0; i < N; i++) begin
            // start_ptr+1+i never exceeds 2N-1, so one conditional subtract is a full mod N.
            pos = {1'b0, start_ptr} + (PW+1)'(1 + i);
            if (pos >= (PW+1)'(N)) begin
                pos = pos - (PW+1)'(N);
            end
            if (!found && vec[pos[PW-1:0]]) begin
                onehot[pos[PW-1:0]] = 1'b1;
                found               = 1'b1;
            end
        end
    end

endmodule

// File: rtl/event_onehot_serializer.sv
// Captures request rising edges into sticky pending bits and issues them one at a time as one-hot words.
// Latency: 2 cycles from req_in rise to out_valid when idle; back-to-back grants at 1 per cycle.
// Backpressure: out_onehot/out_valid held stable while out_ready=0; events keep accumulating in pending.
//
// Ports:
//   clk, rst    single clock, synchronous active-high reset
//   req_in      N  request levels (already synchronised)
//   out_ready   1  downstream accepts the current word
//   out_onehot  N  registered one-hot grant, zero when out_valid=0
//   out_valid   1  out_onehot carries an event
//   pending     N  sticky pending vector (status)
//   overflow    1  sticky: a rise hit a bit that was already pending and not being cleared
//
// Build option: define EVT_SER_ROUND_ROBIN_EN for round-robin selection; default is lowest-index-first.
module event_onehot_serializer
    import evt_ser_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req_in,
    input  logic         out_ready,
    output logic [N-1:0] out_onehot,
    output logic         out_valid,
    output logic [N-1:0] pending,
    output logic         overflow
);

    localparam int PW = idx_width(N);

    state_t        state_q, state_n;
    logic [N-1:0]  req_q;
    logic [N-1:0]  rise;
    logic          fire;
    logic [N-1:0]  clr;
    logic [N-1:0]  pending_n;
    logic [N-1:0]  sel_vec;
    logic [N-1:0]  sel_onehot;
    logic [PW-1:0] start_ptr;
    logic [N-1:0]  onehot_n;
    logic          valid_n;

    assign rise      = req_in & ~req_q;
    assign fire      = out_valid & out_ready;
    assign clr       = fire ? out_onehot : '0;
    // A rise on a bit cleared this cycle survives as a fresh event.
    assign pending_n = (pending & ~clr) | rise;
    // out_onehot is zero in IDLE, so this is just pending there; in HOLD it is the remainder.
    // Rises of this cycle are deliberately excluded until they land in pending.
    assign sel_vec   = pending & ~out_onehot;

    onehot_select #(.N(N), .PW(PW)) u_select (
        .vec       (sel_vec),
        .start_ptr (start_ptr),
        .onehot    (sel_onehot)
    );

`ifdef EVT_SER_ROUND_ROBIN_EN
    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] grant_idx;

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (sel_onehot[i]) begin
                grant_idx = PW'(i);
            end
        end
    end

    // Pointer follows every grant loaded into the output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= PW'(N - 1);
        end else if (((state_q == IDLE) || fire) && (|sel_vec)) begin
            rr_ptr <= grant_idx;
        end
    end

    assign start_ptr = rr_ptr;
`else
    assign start_ptr = PW'(N - 1);
`endif

    always_comb begin
        state_n  = state_q;
        onehot_n = out_onehot;
        valid_n  = out_valid;
        case (state_q)
            IDLE: begin
                if (|sel_vec) begin
                    onehot_n = sel_onehot;
                    valid_n  = 1'b1;
                    state_n  = HOLD;
                end
            end
            HOLD: begin
                if (fire) begin
                    if (|sel_vec) begin
                        onehot_n = sel_onehot;
                    end else begin
                        onehot_n = '0;
                        valid_n  = 1'b0;
                        state_n  = IDLE;
                    end
                end
            end
            default: begin
                onehot_n = '0;
                valid_n  = 1'b0;
                state_n  = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            req_q      <= '0;
            pending    <= '0;
            overflow   <= 1'b0;
            out_onehot <= '0;
            out_valid  <= 1'b0;
        end else begin
            state_q    <= state_n;
            req_q      <= req_in;
            pending    <= pending_n;
            out_onehot <= onehot_n;
            out_valid  <= valid_n;
            if (|(rise & pending & ~clr)) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_event_onehot_serializer.sv
module tb_event_onehot_serializer;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req_in;
    logic         out_ready;
    logic [N-1:0] out_onehot;
    logic         out_valid;
    logic [N-1:0] pending;
    logic         overflow;

    always #5 clk = ~clk;

    event_onehot_serializer #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_in     (req_in),
        .out_ready  (out_ready),
        .out_onehot (out_onehot),
        .out_valid  (out_valid),
        .pending    (pending),
        .overflow   (overflow)
    );

    int           n_checks = 0;
    int           n_pass   = 0;
    logic [N-1:0] exp_q[$];
    logic [N-1:0] exp_g;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Scoreboard: every accepted word must match the next expected grant.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                check_eq("onehot_single", 32'($countones(out_onehot)), 32'd1);
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        check_eq("unexpected_grant", 32'(out_onehot), 32'd0);
                    end else begin
                        exp_g = exp_q.pop_front();
                        check_eq("grant", 32'(out_onehot), 32'(exp_g));
                    end
                end
            end else begin
                check_eq("idle_zero", 32'(out_onehot), 32'd0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        req_in    = '0;
        out_ready = 1'b0;
        tick(3);
        check_eq("rst_valid",    32'(out_valid),  32'd0);
        check_eq("rst_onehot",   32'(out_onehot), 32'd0);
        check_eq("rst_pending",  32'(pending),    32'd0);
        check_eq("rst_overflow", 32'(overflow),   32'd0);
        rst = 1'b0;

        // Single event, 2-cycle latency, one grant while the line stays high.
        out_ready = 1'b1;
        req_in    = 8'h04;
        exp_q.push_back(8'h04);
        tick();
        check_eq("t1_pend_lat",  32'(pending),    32'h04);
        check_eq("t1_valid_lat", 32'(out_valid),  32'd0);
        tick();
        check_eq("t1_valid",     32'(out_valid),  32'd1);
        check_eq("t1_onehot",    32'(out_onehot), 32'h04);
        tick();
        check_eq("t1_drop",      32'(out_valid),  32'd0);
        check_eq("t1_pend_clr",  32'(pending),    32'd0);
        tick(4);
        check_eq("t1_no_repeat", 32'(out_valid),  32'd0);
        check_eq("t1_pend_held", 32'(pending),    32'd0);
        req_in = '0;
        tick(2);

        // Two simultaneous rises, issued back to back.
        req_in = 8'h81;
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h80);
        tick();
        check_eq("t2_pend",   32'(pending),    32'h81);
        tick();
        check_eq("t2_first",  32'(out_onehot), 32'h01);
        tick();
        check_eq("t2_second", 32'(out_onehot), 32'h80);
        check_eq("t2_valid",  32'(out_valid),  32'd1);
        tick();
        check_eq("t2_idle",   32'(out_valid),  32'd0);
        check_eq("t2_pend0",  32'(pending),    32'd0);
        req_in = '0;
        tick(2);

        // Stall: output held stable while out_ready=0.
        out_ready = 1'b0;
        req_in    = 8'h10;
        exp_q.push_back(8'h10);
        tick(2);
        for (int i = 0; i < 5; i++) begin
            check_eq("t3_stall_onehot", 32'(out_onehot), 32'h10);
            check_eq("t3_stall_valid",  32'(out_valid),  32'd1);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check_eq("t3_release_valid", 32'(out_valid), 32'd0);
        check_eq("t3_release_pend",  32'(pending),   32'd0);
        req_in = '0;
        tick();

        // Repeated pulses on a stalled pending bit: overflow, single grant.
        out_ready = 1'b0;
        req_in    = 8'h04;
        exp_q.push_back(8'h04);
        tick();
        req_in = '0;
        tick();
        check_eq("t4_onehot",   32'(out_onehot), 32'h04);
        check_eq("t4_ovf_pre",  32'(overflow),   32'd0);
        req_in = 8'h04;
        tick();
        check_eq("t4_ovf_set",  32'(overflow),   32'd1);
        req_in = '0;
        tick();
        req_in = 8'h04;
        tick();
        req_in = '0;
        tick();
        check_eq("t4_ovf_hold", 32'(overflow),   32'd1);
        check_eq("t4_pend",     32'(pending),    32'h04);
        out_ready = 1'b1;
        tick();
        check_eq("t4_idle",     32'(out_valid),  32'd0);
        check_eq("t4_pend0",    32'(pending),    32'd0);
        tick(3);
        check_eq("t4_ovf_sticky", 32'(overflow), 32'd1);
        check_eq("t4_no_second",  32'(out_valid), 32'd0);

        // Reset while holding a grant with more pending.
        out_ready = 1'b0;
        req_in    = 8'h60;
        tick(2);
        check_eq("t5_pend",   32'(pending),    32'h60);
        check_eq("t5_onehot", 32'(out_onehot), 32'h20);
        rst    = 1'b1;
        req_in = '0;
        tick();
        check_eq("t5_valid",    32'(out_valid),  32'd0);
        check_eq("t5_onehot0",  32'(out_onehot), 32'd0);
        check_eq("t5_pend0",    32'(pending),    32'd0);
        check_eq("t5_overflow", 32'(overflow),   32'd0);

        // Line already high when reset releases counts as a rise.
        req_in = 8'h02;
        tick(2);
        check_eq("t6_in_rst_pend", 32'(pending), 32'd0);
        rst       = 1'b0;
        out_ready = 1'b1;
        exp_q.push_back(8'h02);
        tick();
        check_eq("t6_pend",   32'(pending),    32'h02);
        tick();
        check_eq("t6_onehot", 32'(out_onehot), 32'h02);
        tick();
        check_eq("t6_idle",   32'(out_valid),  32'd0);
        req_in = '0;
        tick();

        // Rise on the bit being accepted: stays pending, no overflow.
        out_ready = 1'b0;
        req_in    = 8'h08;
        exp_q.push_back(8'h08);
        exp_q.push_back(8'h08);
        tick();
        req_in = '0;
        tick();
        check_eq("t7_onehot", 32'(out_onehot), 32'h08);
        req_in    = 8'h08;
        out_ready = 1'b1;
        tick();
        check_eq("t7_no_ovf", 32'(overflow),   32'd0);
        check_eq("t7_pend",   32'(pending),    32'h08);
        check_eq("t7_gap",    32'(out_valid),  32'd0);
        tick();
        check_eq("t7_regrant", 32'(out_onehot), 32'h08);
        tick();
        check_eq("t7_idle",   32'(out_valid),  32'd0);
        check_eq("t7_pend0",  32'(pending),    32'd0);
        req_in = '0;
        tick();

        // Selection order after a grant of bit 5 (wrap 7 -> 0 in round-robin).
        out_ready = 1'b1;
        req_in    = 8'h20;
        exp_q.push_back(8'h20);
        tick(3);
        check_eq("t8_pend_a", 32'(pending), 32'd0);
        req_in = '0;
        tick();
        req_in = 8'h23;
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h02);
        exp_q.push_back(8'h20);
        tick(5);
        check_eq("t8_idle_b", 32'(out_valid), 32'd0);
        check_eq("t8_pend_b", 32'(pending),   32'd0);
        req_in = '0;
        tick();
        req_in = 8'h41;
`ifdef EVT_SER_ROUND_ROBIN_EN
        exp_q.push_back(8'h40);
        exp_q.push_back(8'h01);
`else
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h40);
`endif
        tick(4);
        check_eq("t8_idle_c", 32'(out_valid), 32'd0);
        check_eq("t8_pend_c", 32'(pending),   32'd0);
        req_in = '0;
        tick(2);

        check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
